// File: rtl/spi_ctrl_pkg.sv
// Shared types and helpers for the SPI request arbiter slice.
package spi_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_DONE,
        TIMEOUT,
        RELEASE
    } state_t;

    localparam int DEF_DATA_W = 12;

    function automatic int owner_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_rr_pick.sv
// Combinational round-robin picker: first asserted req after ptr wins.
module spi_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   winner_idx,
    output logic               valid
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        winner     = '0;
        winner_idx = '0;
        valid      = 1'b0;
        cand       = '0;
        // k = 1..NUM_REQ visits ptr+1 first and ptr itself last
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((32'(ptr) + k) % NUM_REQ);
            if (!valid && req[cand]) begin
                valid         = 1'b1;
                winner[cand]  = 1'b1;
                winner_idx    = cand;
            end
        end
    end

endmodule

// File: rtl/spi_req_arbiter.sv
// Round-robin sharing of one SPI master between NUM_REQ requesters,
// with start handshake, completion tracking and timeout recovery.
module spi_req_arbiter
    import spi_ctrl_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int START_TO = 255,
    parameter int XFER_TO  = 1023
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        done,
    output logic                      err,
    output logic                      m_new_data,
    output logic [DATA_W-1:0]         m_din,
    input  logic                      m_busy
);

    localparam int OW    = owner_w(NUM_REQ);
    localparam int CNT_W = $clog2(XFER_TO + 1);
    localparam logic [CNT_W-1:0] START_LIM = CNT_W'(START_TO);
    localparam logic [CNT_W-1:0] XFER_LIM  = CNT_W'(XFER_TO);

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [OW-1:0]      ptr, ptr_n;
    logic [NUM_REQ-1:0] grant_n, done_n;
    logic               err_n, new_n;
    logic [DATA_W-1:0]  din_n;
    logic [NUM_REQ-1:0] pick_hot;
    logic [OW-1:0]      pick_idx;
    logic               pick_valid;
    logic [NUM_REQ-1:0] owner_hot;

    spi_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (OW)
    ) u_pick (
        .req        (req),
        .ptr        (ptr),
        .winner     (pick_hot),
        .winner_idx (pick_idx),
        .valid      (pick_valid)
    );

    // ptr doubles as the owner register: it only moves on grant
    assign owner_hot = NUM_REQ'(1) << ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            ptr        <= OW'(NUM_REQ - 1);
            grant      <= '0;
            done       <= '0;
            err        <= 1'b0;
            m_new_data <= 1'b0;
            m_din      <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            ptr        <= ptr_n;
            grant      <= grant_n;
            done       <= done_n;
            err        <= err_n;
            m_new_data <= new_n;
            m_din      <= din_n;
        end
    end

    // Outputs are computed for the state being entered, so they register in step with it.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ptr_n   = ptr;
        din_n   = m_din;
        grant_n = '0;
        done_n  = '0;
        err_n   = 1'b0;
        new_n   = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid && !m_busy) begin
                    state_n = START;
                    cnt_n   = '0;
                    ptr_n   = pick_idx;
                    din_n   = req_data[pick_idx*DATA_W +: DATA_W];
                    grant_n = pick_hot;
                    new_n   = 1'b1;
                end
            end
            START: begin
                new_n = 1'b1;
                if (m_busy) begin
                    state_n = WAIT_DONE;
                    cnt_n   = '0;
                    new_n   = 1'b0;
                end else if (cnt >= START_LIM) begin
                    state_n = TIMEOUT;
                    cnt_n   = '0;
                    new_n   = 1'b0;
                    done_n  = owner_hot;
                    err_n   = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!m_busy) begin
                    state_n = RELEASE;
                    cnt_n   = '0;
                    done_n  = owner_hot;
                end else if (cnt >= XFER_LIM) begin
                    state_n = TIMEOUT;
                    cnt_n   = '0;
                    done_n  = owner_hot;
                    err_n   = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            TIMEOUT: begin
                state_n = RELEASE;
                cnt_n   = '0;
            end
            RELEASE: begin
                if (!m_busy) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt != '1) begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Directed self-checking bench for spi_req_arbiter with a scripted master busy line.
module tb_spi_req_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 12;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [NUM_REQ-1:0]        req = '0;
    logic [NUM_REQ*DATA_W-1:0] req_data = '0;
    logic [NUM_REQ-1:0]        grant;
    logic [NUM_REQ-1:0]        done;
    logic                      err;
    logic                      m_new_data;
    logic [DATA_W-1:0]         m_din;
    logic                      m_busy = 1'b0;

    int checks   = 0;
    int failures = 0;

    int grant_cnt [NUM_REQ];
    int done_cnt  [NUM_REQ];
    int onehot_bad = 0;
    int pulse_bad  = 0;
    logic [NUM_REQ-1:0] grant_q = '0;
    logic [NUM_REQ-1:0] done_q  = '0;
    logic               err_q   = 1'b0;

    spi_req_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .DATA_W   (DATA_W),
        .START_TO (255),
        .XFER_TO  (1023)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_data   (req_data),
        .grant      (grant),
        .done       (done),
        .err        (err),
        .m_new_data (m_new_data),
        .m_din      (m_din),
        .m_busy     (m_busy)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_cnt[i] = 0;
            done_cnt[i]  = 0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i]) grant_cnt[i]++;
                if (done[i])  done_cnt[i]++;
            end
            if ($countones(grant) > 1 || $countones(done) > 1) onehot_bad++;
            if ((grant != 0 && grant_q != 0) || (done != 0 && done_q != 0) || (err && err_q))
                pulse_bad++;
        end
        grant_q = grant;
        done_q  = done;
        err_q   = err;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        req    = '0;
        m_busy = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    function automatic int gsum();
        int s = 0;
        for (int i = 0; i < NUM_REQ; i++) s += grant_cnt[i];
        return s;
    endfunction

    function automatic int dsum();
        int s = 0;
        for (int i = 0; i < NUM_REQ; i++) s += done_cnt[i];
        return s;
    endfunction

    task automatic wait_grant(output int idx);
        idx = -1;
        for (int n = 0; n < 20 && idx < 0; n++) begin
            step();
            for (int i = 0; i < NUM_REQ; i++)
                if (grant[i]) idx = i;
        end
        check("grant_seen", 32'(idx >= 0), 1);
    endtask

    // Called right after the grant edge; busy rises lat cycles after start, lasts len cycles.
    task automatic serve(input int lat, input int len,
                         output logic [NUM_REQ-1:0] d, output logic e);
        int hi;
        int early;
        hi    = 0;
        early = 0;
        for (int i = 1; i < lat; i++) begin
            if (m_new_data) hi++;
            step();
        end
        check("start_cycles", hi, lat - 1);
        check("start_held", m_new_data, 1);
        m_busy = 1'b1;
        step();
        check("busy_ack", m_new_data, 0);
        if (done != 0) early++;
        for (int i = 1; i < len; i++) begin
            step();
            if (done != 0) early++;
        end
        m_busy = 1'b0;
        step();
        check("no_early_done", early, 0);
        d = done;
        e = err;
    endtask

    initial begin
        int idx;
        int n;
        int g0, d0;
        int snap_g, snap_d;
        int gseen;
        logic [NUM_REQ-1:0] d;
        logic e;
        logic [DATA_W-1:0] exp_d [NUM_REQ];

        // reset state
        do_reset();
        check("rst_grant", grant, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_new", m_new_data, 0);
        check("rst_din", m_din, 0);

        // 1: single requester, nominal transfer
        req_data = {12'h333, 12'hA5C, 12'h111, 12'h000};
        req = 4'b0100;
        step();
        check("t1_grant", grant, 4'b0100);
        check("t1_new", m_new_data, 1);
        check("t1_din", m_din, 12'hA5C);
        req = '0;
        serve(40, 260, d, e);
        check("t1_done", d, 4'b0100);
        check("t1_err", e, 0);
        check("t1_din_hold", m_din, 12'hA5C);
        step();
        check("t1_done_pulse", done, 0);

        // 2: all requesting, round-robin order from reset
        do_reset();
        exp_d[0] = 12'h111;
        exp_d[1] = 12'h222;
        exp_d[2] = 12'h333;
        exp_d[3] = 12'h444;
        req_data = {exp_d[3], exp_d[2], exp_d[1], exp_d[0]};
        g0 = gsum();
        d0 = dsum();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_grant(idx);
            check("t2_order", idx, k % 4);
            check("t2_din", m_din, exp_d[k % 4]);
            if (k == 4) req = '0;
            @(negedge clk);
            #1;
            check("t2_inflight", (gsum() - g0) - (dsum() - d0), 1);
            serve(3, 5, d, e);
            check("t2_done", d, 4'b0001 << (k % 4));
            check("t2_err", e, 0);
        end

        // 3: master never goes busy -> start timeout, then normal service
        req_data[1*DATA_W +: DATA_W] = 12'h7E1;
        req = 4'b0010;
        wait_grant(idx);
        check("t3_owner", idx, 1);
        check("t3_din", m_din, 12'h7E1);
        req = '0;
        n = 0;
        while (m_new_data && n < 400) begin
            n++;
            step();
        end
        check("t3_start_len", n, 256);
        check("t3_done", done, 4'b0010);
        check("t3_err", err, 1);
        step();
        check("t3_err_pulse", err, 0);
        check("t3_done_pulse", done, 0);
        req = 4'b0100;
        wait_grant(idx);
        check("t3_next_owner", idx, 2);
        req = '0;
        serve(2, 3, d, e);
        check("t3_next_done", d, 4'b0100);
        check("t3_next_err", e, 0);

        // 4: reset while in WAIT_DONE
        req = 4'b1000;
        wait_grant(idx);
        check("t4_owner", idx, 3);
        req = '0;
        step();
        m_busy = 1'b1;
        step();
        step();
        step();
        check("t4_in_wait", m_new_data, 0);
        snap_d = done_cnt[3];
        rst    = 1'b1;
        m_busy = 1'b0;
        step();
        rst = 1'b0;
        req = 4'b1001;
        check("t4_new", m_new_data, 0);
        check("t4_grant", grant, 0);
        check("t4_done", done, 0);
        check("t4_err", err, 0);
        check("t4_din", m_din, 0);
        wait_grant(idx);
        check("t4_first_owner", idx, 0);
        req = '0;
        serve(1, 1, d, e);
        check("t4_done0", d, 4'b0001);
        step();
        check("t4_no_done3", done_cnt[3], snap_d);

        // 5: short pulse on req[1] during another transfer
        req_data[2*DATA_W +: DATA_W] = 12'h5A5;
        req = 4'b0100;
        wait_grant(idx);
        check("t5_owner", idx, 2);
        snap_g = grant_cnt[1];
        snap_d = done_cnt[1];
        req = '0;
        step();
        req = 4'b0010;
        step();
        req = '0;
        serve(5, 4, d, e);
        check("t5_done", d, 4'b0100);
        repeat (8) step();
        check("t5_no_grant1", grant_cnt[1], snap_g);
        check("t5_no_done1", done_cnt[1], snap_d);

        // 6: busy rises exactly on the START_TO boundary cycle -> success
        req = 4'b1000;
        wait_grant(idx);
        check("t6_owner", idx, 3);
        req = '0;
        serve(256, 4, d, e);
        check("t6_done", d, 4'b1000);
        check("t6_err", e, 0);

        // master busy while idle blocks the grant
        step();
        m_busy = 1'b1;
        req    = 4'b0001;
        gseen  = 0;
        repeat (4) begin
            step();
            if (grant != 0) gseen++;
        end
        check("busy_idle_hold", gseen, 0);
        m_busy = 1'b0;
        wait_grant(idx);
        check("busy_idle_owner", idx, 0);
        req = '0;
        serve(1, 1, d, e);
        check("busy_idle_done", d, 4'b0001);

        repeat (3) step();
        check("onehot", onehot_bad, 0);
        check("pulse_width", pulse_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
